// File: rtl/dbus_pkg.sv
// Shared types and constants for the dbus link controller.
package dbus_pkg;

   localparam int DBUS_BITS = 8;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_REQ     = 2'd1,
      TX_SEND    = 2'd2,
      TX_BACKOFF = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_READ     = 2'd1,
      RX_WAIT_CLR = 2'd2
   } rx_state_e;

endpackage

// File: rtl/dbus_watchdog.sv
// Saturating transaction watchdog with a sticky expiry flag.
// i_clear drops the flag and also restarts the count, so an engine that is
// still stuck raises the flag again after another LIMIT cycles. A flag set
// event in the same cycle as i_clear wins.
module dbus_watchdog #(
   parameter logic [23:0] LIMIT = 24'd4_000_000
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_restart,
   input  logic i_run,
   input  logic i_clear,
   output logic o_flag
);

   logic [23:0] cnt_q, cnt_d;
   logic        flag_q, flag_d;
   logic        hit_s;

   // Next count, expiry detection and sticky flag update.
   always_comb begin
      cnt_d  = cnt_q;
      hit_s  = 1'b0;
      flag_d = flag_q;
      if (i_restart || i_clear) begin
         cnt_d = 24'd0;
      end else if (i_run && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 24'd1;
      end else begin
         cnt_d = cnt_q;
      end
      if (!i_restart && i_run && ((cnt_q + 24'd1) == LIMIT)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      flag_d = hit_s | (flag_q & ~i_clear);
   end

   // Counter and flag registers.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q  <= 24'd0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign o_flag = flag_q;

endmodule

// File: rtl/dbus_link_ctrl.sv
// Sequencer between a valid/ready byte stream and the dbus line engine:
// times transmit requests, retries pre-empted sends, drains received bytes
// and keeps wrap-around byte counters.
module dbus_link_ctrl
   import dbus_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
   parameter int          CNT_W          = 16
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [7:0]       i_tx_data,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic [7:0]       o_rx_data,
   output logic             o_rx_valid,
   input  logic             i_rx_ready,
   output logic [7:0]       o_db_data,
   output logic             o_db_enable,
   output logic             o_db_read,
   input  logic [7:0]       i_db_data,
   input  logic             i_db_busy,
   input  logic             i_db_avail,
   input  logic             i_db_receiving,
   input  logic             i_clear,
   output logic             o_timeout,
   output logic             o_preempted,
   output logic [CNT_W-1:0] o_tx_count,
   output logic [CNT_W-1:0] o_rx_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   tx_state_e              tx_state_q, tx_state_d;
   rx_state_e              rx_state_q, rx_state_d;
   logic                   tx_full_q, tx_full_d;
   logic [DBUS_BITS-1:0]   db_data_q, db_data_d;
   logic                   db_enable_q, db_enable_d;
   logic                   db_read_q, db_read_d;
   logic [DBUS_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   preempt_q, preempt_d;
   logic [CNT_W-1:0]       tx_count_q, tx_count_d;
   logic [CNT_W-1:0]       rx_count_q, rx_count_d;
   logic                   busy_q;
   logic                   preempt_set_s;
   logic                   wd_restart_s;
   logic                   wd_run_s;

   // TX holding register and TX FSM; enable is high only while in REQ.
   always_comb begin
      tx_state_d    = tx_state_q;
      tx_full_d     = tx_full_q;
      db_data_d     = db_data_q;
      tx_count_d    = tx_count_q;
      preempt_set_s = 1'b0;
      if (i_tx_valid && !tx_full_q) begin
         tx_full_d = 1'b1;
         db_data_d = i_tx_data;
      end else begin
         db_data_d = db_data_q;
      end
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_full_q && !i_db_busy) begin
               tx_state_d = TX_REQ;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_REQ: begin
            if (i_db_busy && i_db_receiving) begin
               tx_state_d    = TX_BACKOFF;
               preempt_set_s = 1'b1;
            end else if (i_db_busy) begin
               tx_state_d = TX_SEND;
            end else begin
               tx_state_d = TX_REQ;
            end
         end
         TX_SEND: begin
            if (!i_db_busy) begin
               tx_state_d = TX_IDLE;
               tx_full_d  = 1'b0;
               tx_count_d = tx_count_q + CNT_ONE;
            end else begin
               tx_state_d = TX_SEND;
            end
         end
         TX_BACKOFF: begin
            if (!i_db_busy) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_state_d = TX_BACKOFF;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      db_enable_d = (tx_state_d == TX_REQ);
      preempt_d   = preempt_set_s | (preempt_q & ~i_clear);
   end

   // RX FSM: one read pulse per byte, then wait for avail to drop.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_count_d = rx_count_q;
      if (rx_valid_q && i_rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
      case (rx_state_q)
         RX_IDLE: begin
            if (i_db_avail && !rx_valid_q) begin
               rx_state_d = RX_READ;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_READ: begin
            rx_state_d = RX_WAIT_CLR;
            rx_data_d  = i_db_data;
            rx_valid_d = 1'b1;
            rx_count_d = rx_count_q + CNT_ONE;
         end
         RX_WAIT_CLR: begin
            if (!i_db_avail) begin
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_WAIT_CLR;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      db_read_d = (rx_state_d == RX_READ);
   end

   // Watchdog restarts on any FSM move or falling busy.
   always_comb begin
      wd_restart_s = (tx_state_d != tx_state_q) || (rx_state_d != rx_state_q) ||
                     (busy_q && !i_db_busy);
      wd_run_s     = (tx_state_q != TX_IDLE) || i_db_busy;
   end

   // State and output registers.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tx_state_q  <= TX_IDLE;
         rx_state_q  <= RX_IDLE;
         tx_full_q   <= 1'b0;
         db_data_q   <= 8'h00;
         db_enable_q <= 1'b0;
         db_read_q   <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         preempt_q   <= 1'b0;
         tx_count_q  <= '0;
         rx_count_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         rx_state_q  <= rx_state_d;
         tx_full_q   <= tx_full_d;
         db_data_q   <= db_data_d;
         db_enable_q <= db_enable_d;
         db_read_q   <= db_read_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         preempt_q   <= preempt_d;
         tx_count_q  <= tx_count_d;
         rx_count_q  <= rx_count_d;
         busy_q      <= i_db_busy;
      end
   end

   dbus_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_restart (wd_restart_s),
      .i_run     (wd_run_s),
      .i_clear   (i_clear),
      .o_flag    (o_timeout)
   );

   assign o_tx_ready  = ~tx_full_q;
   assign o_db_data   = db_data_q;
   assign o_db_enable = db_enable_q;
   assign o_db_read   = db_read_q;
   assign o_rx_data   = rx_data_q;
   assign o_rx_valid  = rx_valid_q;
   assign o_preempted = preempt_q;
   assign o_tx_count  = tx_count_q;
   assign o_rx_count  = rx_count_q;

endmodule

// File: tb/tb_dbus_link_ctrl.sv
// Directed bench for dbus_link_ctrl: a cycle vector table followed by
// hand-written multi-cycle sequences with the engine played by tasks.
module tb_dbus_link_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] db_data_o;
   logic       db_enable;
   logic       db_read;
   logic [7:0] db_data_i;
   logic       db_busy;
   logic       db_avail;
   logic       db_recv;
   logic       clr;
   logic       timeout;
   logic       preempted;
   logic [3:0] tx_count;
   logic [3:0] rx_count;

   int errors = 0;
   int checks = 0;

   dbus_link_ctrl #(.TIMEOUT_CYCLES(24'd100), .CNT_W(4)) dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_tx_data      (tx_data),
      .i_tx_valid     (tx_valid),
      .o_tx_ready     (tx_ready),
      .o_rx_data      (rx_data),
      .o_rx_valid     (rx_valid),
      .i_rx_ready     (rx_ready),
      .o_db_data      (db_data_o),
      .o_db_enable    (db_enable),
      .o_db_read      (db_read),
      .i_db_data      (db_data_i),
      .i_db_busy      (db_busy),
      .i_db_avail     (db_avail),
      .i_db_receiving (db_recv),
      .i_clear        (clr),
      .o_timeout      (timeout),
      .o_preempted    (preempted),
      .o_tx_count     (tx_count),
      .o_rx_count     (rx_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       tv;  logic [7:0] td;  logic busy; logic recv;
      logic       av;  logic [7:0] dd;  logic rrdy; logic clr;
      logic       rdy; logic en; logic [7:0] dbd; logic rd; logic rv;
      logic [7:0] rxd; logic pre; logic [3:0] tc; logic [3:0] rc;
   } vec_t;

   vec_t vecs [24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic busy_lvl);
      rst_n    = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; db_data_i = 8'h00;
      db_busy  = busy_lvl; db_avail = 1'b0; db_recv = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tx_valid = 1'b1; tx_data = b;
      step();
      tx_valid = 1'b0;
   endtask

   // Engine: busy rises two cycles after enable is seen, lasts nbusy cycles.
   task automatic engine_tx(input logic recv, input int nbusy);
      int w = 0;
      int bad = 0;
      while (!db_enable && w < 20) begin
         step();
         w++;
      end
      check("en_raise", {31'd0, db_enable}, 32'd1);
      repeat (2) begin
         step();
         check("en_hold", {31'd0, db_enable}, 32'd1);
      end
      db_busy = 1'b1; db_recv = recv;
      step();
      check("en_drop", {31'd0, db_enable}, 32'd0);
      for (int k = 1; k < nbusy; k++) begin
         step();
         if (db_enable) bad++;
      end
      check("en_low_busy", bad, 32'd0);
      db_busy = 1'b0; db_recv = 1'b0;
      step();
   endtask

   initial begin
      int reads;
      int bad;
      int w;
      vecs[0]  = '{1'b1,8'hA5,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd0,4'd0};
      vecs[1]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd0,4'd0};
      vecs[2]  = '{1'b1,8'hFF,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd0,4'd0};
      vecs[3]  = '{1'b0,8'h00,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd0,4'd0};
      vecs[4]  = '{1'b0,8'h00,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd0,4'd0};
      vecs[5]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd1,4'd0};
      vecs[6]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b0,8'h00,1'b0,4'd1,4'd0};
      vecs[7]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b1,1'b0,8'h00,1'b0,4'd1,4'd0};
      vecs[8]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b1,8'h5A,1'b0,4'd1,4'd1};
      vecs[9]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b1,8'h5A,1'b0,4'd1,4'd1};
      vecs[10] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b1,8'h5A,1'b0,4'd1,4'd1};
      vecs[11] = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h77,1'b0,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b1,8'h5A,1'b0,4'd1,4'd1};
      vecs[12] = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h77,1'b1,1'b0, 1'b1,1'b0,8'hA5,1'b0,1'b0,8'h5A,1'b0,4'd1,4'd1};
      vecs[13] = '{1'b1,8'h3C,1'b0,1'b0,1'b1,8'h77,1'b0,1'b0, 1'b0,1'b0,8'h3C,1'b1,1'b0,8'h5A,1'b0,4'd1,4'd1};
      vecs[14] = '{1'b0,8'h00,1'b0,1'b0,1'b1,8'h77,1'b0,1'b0, 1'b0,1'b1,8'h3C,1'b0,1'b1,8'h77,1'b0,4'd1,4'd2};
      vecs[15] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,1'b1,8'h3C,1'b0,1'b0,8'h77,1'b0,4'd1,4'd2};
      vecs[16] = '{1'b0,8'h00,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd1,4'd2};
      vecs[17] = '{1'b0,8'h00,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd1,4'd2};
      vecs[18] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd1,4'd2};
      vecs[19] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd1,4'd2};
      vecs[20] = '{1'b0,8'h00,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd1,4'd2};
      vecs[21] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b1,4'd2,4'd2};
      vecs[22] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b0,4'd2,4'd2};
      vecs[23] = '{1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h3C,1'b0,1'b0,8'h77,1'b0,4'd2,4'd2};

      rst_n = 1'b1;
      #2;
      do_reset(1'b0);
      check("reset_outputs",
            {3'd0, tx_ready, db_enable, db_data_o, db_read, rx_valid, rx_data, preempted, tx_count, rx_count},
            {3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0});
      check("reset_timeout", {31'd0, timeout}, 32'd0);

      // Cycle-by-cycle vector table.
      for (int i = 0; i < 24; i++) begin
         tx_valid = vecs[i].tv; tx_data = vecs[i].td; db_busy = vecs[i].busy; db_recv = vecs[i].recv;
         db_avail = vecs[i].av; db_data_i = vecs[i].dd; rx_ready = vecs[i].rrdy; clr = vecs[i].clr;
         step();
         check($sformatf("vec%0d", i),
               {3'd0, tx_ready, db_enable, db_data_o, db_read, rx_valid, rx_data, preempted, tx_count, rx_count},
               {3'd0, vecs[i].rdy, vecs[i].en, vecs[i].dbd, vecs[i].rd, vecs[i].rv, vecs[i].rxd,
                vecs[i].pre, vecs[i].tc, vecs[i].rc});
      end

      // Plain send with a 40-cycle busy period.
      do_reset(1'b0);
      send_byte(8'hA5);
      check("t1_ready_low", {31'd0, tx_ready}, 32'd0);
      engine_tx(1'b0, 40);
      check("t1_ready_back", {31'd0, tx_ready}, 32'd1);
      check("t1_tx_count", {28'd0, tx_count}, 32'd1);

      // Pre-empted send, incoming byte drained, then retried.
      do_reset(1'b0);
      send_byte(8'hA5);
      engine_tx(1'b1, 6);
      check("t2_preempted", {31'd0, preempted}, 32'd1);
      check("t2_byte_kept", {31'd0, tx_ready}, 32'd0);
      check("t2_count_zero", {28'd0, tx_count}, 32'd0);
      db_avail = 1'b1; db_data_i = 8'h3C;
      step();
      step();
      db_avail = 1'b0;
      engine_tx(1'b0, 5);
      check("t2_rx_data", {24'd0, rx_data}, 32'h3C);
      check("t2_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("t2_tx_count", {28'd0, tx_count}, 32'd1);
      check("t2_rx_count", {28'd0, rx_count}, 32'd1);
      check("t2_retry_data", {24'd0, db_data_o}, 32'hA5);

      // Avail held after read with consumer stalled: single read pulse.
      do_reset(1'b0);
      db_data_i = 8'h99;
      reads = 0;
      for (int k = 0; k < 10; k++) begin
         db_avail = (k < 4);
         step();
         if (db_read) reads++;
      end
      check("t3_read_pulses", reads, 32'd1);
      check("t3_rx_valid_held", {31'd0, rx_valid}, 32'd1);
      check("t3_rx_data", {24'd0, rx_data}, 32'h99);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      check("t3_rx_valid_clr", {31'd0, rx_valid}, 32'd0);
      check("t3_rx_count", {28'd0, rx_count}, 32'd1);

      // Watchdog with busy stuck high from reset.
      do_reset(1'b1);
      repeat (99) step();
      check("t4_not_yet", {31'd0, timeout}, 32'd0);
      step();
      check("t4_timeout", {31'd0, timeout}, 32'd1);
      check("t4_tx_ready", {31'd0, tx_ready}, 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_cleared", {31'd0, timeout}, 32'd0);
      repeat (99) step();
      check("t4_still_clr", {31'd0, timeout}, 32'd0);
      step();
      check("t4_reset", {31'd0, timeout}, 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (99) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_set_wins", {31'd0, timeout}, 32'd1);

      // 17 back-to-back bytes on a 4-bit counter.
      do_reset(1'b0);
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         send_byte(8'(i + 16));
         if (db_enable) bad++;
         if (db_data_o != 8'(i + 16)) bad++;
         engine_tx(1'b0, 3);
         if (db_enable) bad++;
         if (i == 15) check("t5_wrap_zero", {28'd0, tx_count}, 32'd0);
      end
      check("t5_gap_enable", bad, 32'd0);
      check("t5_tx_count", {28'd0, tx_count}, 32'd1);

      // Reset asserted while the engine is sending.
      do_reset(1'b0);
      send_byte(8'h5E);
      w = 0;
      while (!db_enable && w < 20) begin
         step();
         w++;
      end
      check("t6_en_raise", {31'd0, db_enable}, 32'd1);
      db_busy = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("t6_en_reset", {31'd0, db_enable}, 32'd0);
      check("t6_ready_reset", {31'd0, tx_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_byte(8'hC3);
      bad = 0;
      repeat (5) begin
         step();
         if (db_enable) bad++;
      end
      check("t6_wait_busy", bad, 32'd0);
      db_busy = 1'b0;
      step();
      check("t6_en_after", {31'd0, db_enable}, 32'd1);
      engine_tx(1'b0, 3);
      check("t6_tx_count", {28'd0, tx_count}, 32'd1);
      check("t6_db_data", {24'd0, db_data_o}, 32'hC3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dbus_link_ctrl.md
Name: dbus_link_ctrl

Overview:
Sequencer placed in front of the dbus TI-link line engine. It turns a valid/ready byte stream from the UART side into correctly timed `o_db_enable` requests, and drains received bytes with `o_db_read` pulses into a valid/ready output stream. It detects when a transmit attempt is pre-empted by an incoming byte and retries it. It watches for stuck handshakes and keeps wrap-around byte counters.

Parameters:
TIMEOUT_CYCLES, 24'd4_000_000, cycles a single engine transaction may stay busy (or a request may go unanswered) before `o_timeout` sets
CNT_W, 16, width of the TX/RX byte counters

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_tx_data  in  8  byte to send
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  holding register empty; byte accepted when valid&&ready
o_rx_data  out  8  received byte
o_rx_valid  out  1  o_rx_data valid
i_rx_ready  in  1  consumer takes byte when valid&&ready
o_db_data  out  8  byte to engine (registered copy of TX holding register)
o_db_enable  out  1  transmit request to engine
o_db_read  out  1  one-cycle acknowledge of engine RX byte
i_db_data  in  8  engine received byte
i_db_busy  in  1  engine busy (TX or RX)
i_db_avail  in  1  engine has an unread RX byte
i_db_receiving  in  1  engine busy because of RX
i_clear  in  1  clears o_timeout and o_preempted
o_timeout  out  1  sticky: engine transaction exceeded TIMEOUT_CYCLES
o_preempted  out  1  sticky: at least one TX attempt lost to incoming RX
o_tx_count  out  CNT_W  bytes completed on the line, wraps
o_rx_count  out  CNT_W  bytes drained from the engine, wraps

Behaviour:
- Reset values: all outputs 0, except `o_tx_ready` = 1. Both FSMs reset to IDLE. The engine has no reset, so the controller must tolerate `i_db_busy` = 1 when leaving reset.
- TX holding register `tx_full`:
  - `o_tx_ready` = !tx_full.
  - On accept: latch `i_tx_data` into both the holding register and `o_db_data`, and set tx_full.
  - No new accept until the current byte completes.
- TX FSM:
  - IDLE: if tx_full && !i_db_busy -> REQ.
  - REQ: `o_db_enable` = 1 (registered). Wait for `i_db_busy` = 1; the engine registers enable, so busy appears about 2 cycles later.
    - On busy with `i_db_receiving` = 1: go to BACKOFF, drop enable, set `o_preempted`.
    - On busy with `i_db_receiving` = 0: go to SEND, drop enable.
  - SEND: on `i_db_busy` = 0 -> IDLE. Clear tx_full and increment `o_tx_count` in that same cycle.
  - BACKOFF: on `i_db_busy` = 0 -> IDLE, keeping the byte. It is retried automatically.
  - `o_db_enable` must never be high outside REQ. This prevents the engine's level-sensitive enable from re-launching a byte.
- RX FSM:
  - IDLE: if `i_db_avail` && !rx_valid -> READ.
  - READ: pulse `o_db_read` for exactly 1 cycle, capture `i_db_data` into `o_rx_data`, set `o_rx_valid`, increment `o_rx_count`, then go to WAIT_CLR.
  - WAIT_CLR: stay until `i_db_avail` = 0 (engine clears it about 2 cycles after read), then go to IDLE. This blocks a double read.
  - `o_rx_valid` clears on valid&&ready. Draining promptly matters, because the engine refuses new RX while avail is set.
- Watchdog:
  - The counter loads 0 on every TX/RX FSM transition or whenever `i_db_busy` falls.
  - It increments while TX is in REQ/SEND/BACKOFF or `i_db_busy` = 1, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, set `o_timeout`.
  - `o_timeout` does not abort the FSMs, and `o_tx_ready` is unaffected.
- `i_clear`: clears both sticky flags in 1 cycle. If it coincides with a set event, set wins.
- Simultaneous events:
  - A TX accept and an RX read may occur in the same cycle.
  - Counter increments are independent.
  - Counters wrap from 2^CNT_W-1 to 0.
- Reset mid-transfer: reset returns the FSMs to IDLE with `o_db_enable` = 0. Any pending byte is dropped. TX cannot restart until `i_db_busy` is low.

Decomposition:
- Package `dbus_pkg`:
  - TX state enum {IDLE, REQ, SEND, BACKOFF}
  - RX state enum {IDLE, READ, WAIT_CLR}
  - constant DBUS_BITS = 8
- Sub-module `dbus_watchdog`: saturating counter with restart/run inputs and a sticky flag output. It is the natural split. Everything else stays in one module.

Test Plan:
1. Reset, then send 0xA5 with an engine model; busy rises 2 cycles after enable and stays 40 cycles -> enable high exactly until busy is seen, `o_tx_count` = 1, `o_tx_ready` returns to 1 the cycle after busy falls.
2. Enable pending while the model raises busy with receiving = 1 and delivers 0x3C -> `o_preempted` = 1, `o_rx_data` = 0x3C, then 0xA5 retried and completed, `o_tx_count` = 1.
3. Model holds avail for 3 cycles after read, with `i_rx_ready` = 0 -> exactly one `o_db_read` pulse, and `o_rx_valid` stays set until ready.
4. TIMEOUT_CYCLES = 100, busy stuck high -> `o_timeout` = 1 at cycle 100; `i_clear` clears it for 1 cycle, then it re-sets 100 cycles later.
5. Set CNT_W = 4 and send 17 bytes -> `o_tx_count` = 1; back-to-back bytes keep enable low between transfers.
6. Assert reset during SEND -> enable 0 immediately; after release, a new byte is not requested until busy drops.
